// File: rtl/sva_result_collector.sv
// sva_result_collector: gathers the result strobes of an SVA checker FSM on sys_clk.
// It keeps saturating per-kind counters, a pass/fail verdict, the period of the first
// failure, and a FIFO of timestamped events drained over a valid/ready port.
// Optional watchdog: define SVA_COLLECT_TIMEOUT_EN to fail after TIMEOUT_PERIODS
// user-clock periods in RUN with no accepted result.
module sva_result_collector #(
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned PERIOD_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned TIMEOUT_PERIODS = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    grst,
    input  logic                    en,
    input  logic                    period_tick,
    input  logic                    res_vld,
    input  logic                    succ,
    input  logic                    fail,
    input  logic                    lazy_succ,
    output logic [CNT_WIDTH-1:0]    succ_cnt,
    output logic [CNT_WIDTH-1:0]    fail_cnt,
    output logic [CNT_WIDTH-1:0]    lazy_cnt,
    output logic [1:0]              verdict,
    output logic [PERIOD_WIDTH-1:0] first_fail_period,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [1:0]              ev_kind,
    output logic [PERIOD_WIDTH-1:0] ev_period,
    output logic                    ev_overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        V_IDLE = 2'b00,
        V_RUN  = 2'b01,
        V_PASS = 2'b10,
        V_FAIL = 2'b11
    } verdict_e;

    localparam logic [1:0] K_TIMEOUT = 2'b00;
    localparam logic [1:0] K_SUCC    = 2'b01;
    localparam logic [1:0] K_FAIL    = 2'b10;
    localparam logic [1:0] K_LAZY    = 2'b11;

    typedef struct packed {
        logic [1:0]              kind;
        logic [PERIOD_WIDTH-1:0] period;
    } ev_t;

    verdict_e                verdict_q, verdict_d;
    logic [CNT_WIDTH-1:0]    succ_cnt_q, succ_cnt_d;
    logic [CNT_WIDTH-1:0]    fail_cnt_q, fail_cnt_d;
    logic [CNT_WIDTH-1:0]    lazy_cnt_q, lazy_cnt_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] first_fail_q, first_fail_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ev_valid_q, ev_valid_d;
    ev_t                     head_q, head_d;
    logic                    overflow_q, overflow_d;
    ev_t                     mem_q [FIFO_DEPTH];

    logic active_c, accept_c, timeout_c, fail_hit_c;
    logic push_c, push_ok_c, pop_c, full_c;
    ev_t  new_ev_c;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic inc);
        return (inc && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    assign active_c = (verdict_q == V_RUN) || (verdict_q == V_FAIL);
    assign accept_c = res_vld && active_c;

`ifdef SVA_COLLECT_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_PERIODS + 1);
    logic [WDW-1:0] wd_q, wd_d;

    // Watchdog: counts periods in RUN, cleared by any accepted result
    always_comb begin
        timeout_c = 1'b0;
        wd_d      = wd_q;
        if (verdict_q == V_RUN) begin
            if (accept_c) begin
                wd_d = '0;
            end else if (period_tick) begin
                if (wd_q == WDW'(TIMEOUT_PERIODS - 1)) begin
                    timeout_c = 1'b1;
                    wd_d      = '0;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
        end
        if (grst) begin
            timeout_c = 1'b0;
            wd_d      = '0;
        end
    end

    // Watchdog register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) wd_q <= '0;
        else         wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign timeout_c      = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT_PERIODS);
`endif

    assign fail_hit_c = (accept_c && fail) || timeout_c;
    assign push_c     = (accept_c && (succ || fail || lazy_succ)) || timeout_c;
    assign pop_c      = ev_valid_q && ev_ready;
    assign full_c     = (count_q == CW'(FIFO_DEPTH));
    assign push_ok_c  = push_c && (!full_c || pop_c) && !grst;

    // Event payload: priority timeout/fail > succ > lazy, stamped with the current period
    always_comb begin
        new_ev_c.period = period_q;
        if (timeout_c)  new_ev_c.kind = K_TIMEOUT;
        else if (fail)  new_ev_c.kind = K_FAIL;
        else if (succ)  new_ev_c.kind = K_SUCC;
        else            new_ev_c.kind = K_LAZY;
    end

    // Next state: verdict, counters, period, FIFO bookkeeping
    always_comb begin
        verdict_d    = verdict_q;
        succ_cnt_d   = sat_inc(succ_cnt_q, accept_c && succ);
        fail_cnt_d   = sat_inc(fail_cnt_q, fail_hit_c);
        lazy_cnt_d   = sat_inc(lazy_cnt_q, accept_c && lazy_succ);
        period_d     = (active_c && period_tick) ? period_q + PERIOD_WIDTH'(1) : period_q;
        first_fail_d = first_fail_q;
        wr_ptr_d     = push_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q || (push_c && full_c && !pop_c);
        head_d       = head_q;

        case (verdict_q)
            V_IDLE: if (en) verdict_d = V_RUN;
            V_RUN: begin
                if (fail_hit_c) begin
                    verdict_d    = V_FAIL;
                    first_fail_d = period_q;
                end else if (!en) begin
                    verdict_d = (succ_cnt_q != '0 && fail_cnt_q == '0) ? V_PASS : V_IDLE;
                end
            end
            V_PASS: if (en) verdict_d = V_RUN;
            default: verdict_d = V_FAIL;
        endcase

        if (push_ok_c && !pop_c)      count_d = count_q + CW'(1);
        else if (!push_ok_c && pop_c) count_d = count_q - CW'(1);

        ev_valid_d = (count_d != '0);
        if (ev_valid_d) begin
            head_d = (push_ok_c && rd_ptr_d == wr_ptr_q) ? new_ev_c : mem_q[rd_ptr_d];
        end

        if (grst) begin
            verdict_d    = V_IDLE;
            succ_cnt_d   = '0;
            fail_cnt_d   = '0;
            lazy_cnt_d   = '0;
            period_d     = '0;
            first_fail_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            ev_valid_d   = 1'b0;
            head_d       = '0;
        end
    end

    // State registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            verdict_q    <= V_IDLE;
            succ_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            lazy_cnt_q   <= '0;
            period_q     <= '0;
            first_fail_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            ev_valid_q   <= 1'b0;
            head_q       <= '0;
        end else begin
            verdict_q    <= verdict_d;
            succ_cnt_q   <= succ_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            lazy_cnt_q   <= lazy_cnt_d;
            period_q     <= period_d;
            first_fail_q <= first_fail_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            ev_valid_q   <= ev_valid_d;
            head_q       <= head_d;
        end
    end

    // Event storage
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok_c) begin
            mem_q[wr_ptr_q] <= new_ev_c;
        end
    end

    assign succ_cnt          = succ_cnt_q;
    assign fail_cnt          = fail_cnt_q;
    assign lazy_cnt          = lazy_cnt_q;
    assign verdict           = verdict_q;
    assign first_fail_period = first_fail_q;
    assign ev_valid          = ev_valid_q;
    assign ev_kind           = head_q.kind;
    assign ev_period         = head_q.period;
    assign ev_overflow       = overflow_q;

endmodule

// File: tb/tb_sva_result_collector.sv
// Bench for sva_result_collector: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the collector's rules.
module tb_sva_result_collector;

    localparam int unsigned CW    = 4;
    localparam int unsigned PW    = 6;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int PMOD = 1 << PW;

    logic clk = 1'b0;
    logic sys_rst = 1'b1, grst = 1'b0, en = 1'b0, tick = 1'b0, vld = 1'b0;
    logic s = 1'b0, f = 1'b0, l = 1'b0, rdy = 1'b0;
    logic [CW-1:0] succ_cnt, fail_cnt, lazy_cnt;
    logic [1:0]    verdict, ev_kind;
    logic [PW-1:0] first_fail_period, ev_period;
    logic          ev_valid, ev_overflow;

    always #5 clk = ~clk;

    sva_result_collector #(
        .CNT_WIDTH(CW), .PERIOD_WIDTH(PW), .FIFO_DEPTH(DEPTH), .TIMEOUT_PERIODS(TO)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .grst(grst), .en(en), .period_tick(tick),
        .res_vld(vld), .succ(s), .fail(f), .lazy_succ(l),
        .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .lazy_cnt(lazy_cnt),
        .verdict(verdict), .first_fail_period(first_fail_period),
        .ev_valid(ev_valid), .ev_ready(rdy), .ev_kind(ev_kind), .ev_period(ev_period),
        .ev_overflow(ev_overflow)
    );

    // ---------------- reference model ----------------
    typedef struct {int kind; int period;} ev_s;
    ev_s q[$];
    int  m_v, m_s, m_f, m_l, m_p, m_ff, m_wd;
    bit  m_over;
    int  n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_clear();
        q.delete();
        m_v = 0; m_s = 0; m_f = 0; m_l = 0; m_p = 0; m_ff = 0; m_wd = 0; m_over = 0;
    endfunction

    function automatic void m_step();
        int  v0 = m_v;
        int  s0 = m_s;
        int  f0 = m_f;
        bit  act = (v0 == 1) || (v0 == 3);
        bit  acc = vld && act;
        bit  to = 0;
        bit  isf, pushing, popping, full;
        ev_s e;
        if (grst) begin
            m_clear();
            return;
        end
`ifdef SVA_COLLECT_TIMEOUT_EN
        if (v0 == 1 && !acc && tick && m_wd == TO - 1) to = 1;
        if (v0 == 1) begin
            if (acc) m_wd = 0;
            else if (tick) m_wd = to ? 0 : m_wd + 1;
        end
`endif
        isf     = (acc && f) || to;
        pushing = (acc && (s || f || l)) || to;
        full    = (q.size() == DEPTH);
        popping = (q.size() > 0) && rdy;
        e.kind   = to ? 0 : f ? 2 : s ? 1 : 3;
        e.period = m_p;
        if (popping) void'(q.pop_front());
        if (pushing) begin
            if (full && !popping) m_over = 1;
            else q.push_back(e);
        end
        if (acc && s && m_s < CMAX) m_s++;
        if (isf && m_f < CMAX) m_f++;
        if (acc && l && m_l < CMAX) m_l++;
        case (v0)
            0: if (en) m_v = 1;
            1: if (isf) begin m_v = 3; m_ff = m_p; end
               else if (!en) m_v = (s0 > 0 && f0 == 0) ? 2 : 0;
            2: if (en) m_v = 1;
            default: m_v = 3;
        endcase
        if (act && tick) m_p = (m_p + 1) % PMOD;
    endfunction

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) m_clear();
        else m_step();
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!sys_rst) begin
            chk("cmp_verdict", int'(verdict), m_v);
            chk("cmp_succ_cnt", int'(succ_cnt), m_s);
            chk("cmp_fail_cnt", int'(fail_cnt), m_f);
            chk("cmp_lazy_cnt", int'(lazy_cnt), m_l);
            chk("cmp_first_fail", int'(first_fail_period), m_ff);
            chk("cmp_overflow", int'(ev_overflow), int'(m_over));
            chk("cmp_ev_valid", int'(ev_valid), int'(q.size() > 0));
            if (q.size() > 0) begin
                chk("cmp_ev_kind", int'(ev_kind), q[0].kind);
                chk("cmp_ev_period", int'(ev_period), q[0].period);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit e_, t_, v_, s_, f_, l_, r_);
        @(negedge clk);
        grst = 0; en = e_; tick = t_; vld = v_; s = s_; f = f_; l = l_; rdy = r_;
    endtask

    task automatic do_grst();
        @(negedge clk);
        grst = 1; en = 0; tick = 0; vld = 0; s = 0; f = 0; l = 0; rdy = 0;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_verdict", int'(verdict), 0);
        chk("rst_succ_cnt", int'(succ_cnt), 0);
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_ev_kind", int'(ev_kind), 0);
        chk("rst_ev_period", int'(ev_period), 0);
        chk("rst_overflow", int'(ev_overflow), 0);
        chk("rst_first_fail", int'(first_fail_period), 0);
        sys_rst = 0;

        // Scenario 1: three periods, one succ at period 3, then en falls -> PASS
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        look();
        chk("t1_verdict", int'(verdict), 2);
        chk("t1_succ_cnt", int'(succ_cnt), 1);
        chk("t1_ev_valid", int'(ev_valid), 1);
        chk("t1_ev_kind", int'(ev_kind), 1);
        chk("t1_ev_period", int'(ev_period), 3);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        look();
        chk("t1_drained", int'(ev_valid), 0);

        // Scenario 2: fail at period 5, succ at period 6
        do_grst();
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (5) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        look();
        chk("t2_verdict", int'(verdict), 3);
        chk("t2_first_fail", int'(first_fail_period), 5);
        chk("t2_fail_cnt", int'(fail_cnt), 1);
        chk("t2_succ_cnt", int'(succ_cnt), 1);
        chk("t2_ev0_kind", int'(ev_kind), 2);
        chk("t2_ev0_period", int'(ev_period), 5);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        look();
        chk("t2_ev1_kind", int'(ev_kind), 1);
        chk("t2_ev1_period", int'(ev_period), 6);

        // Scenario 3: ten succ events into an 8-entry FIFO with no consumer
        do_grst();
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (10) step(1, 1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        look();
        chk("t3_succ_cnt", int'(succ_cnt), 10);
        chk("t3_overflow", int'(ev_overflow), 1);
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_valid", int'(ev_valid), 1);
            chk("t3_drain_period", int'(ev_period), i);
            step(1, 0, 0, 0, 0, 0, 1);
            step(1, 0, 0, 0, 0, 0, 0);
            look();
        end
        chk("t3_empty", int'(ev_valid), 0);

        // Scenario 4: succ and fail together -> one fail event
        do_grst();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        look();
        chk("t4_succ_cnt", int'(succ_cnt), 1);
        chk("t4_fail_cnt", int'(fail_cnt), 1);
        chk("t4_ev_kind", int'(ev_kind), 2);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        look();
        chk("t4_single_event", int'(ev_valid), 0);

        // Scenario 5: lazy counter saturates, then grst clears everything
        do_grst();
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (20) step(1, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        look();
        chk("t5_lazy_sat", int'(lazy_cnt), 15);
        do_grst();
        step(0, 0, 0, 0, 0, 0, 0);
        look();
        chk("t5_lazy_clr", int'(lazy_cnt), 0);
        chk("t5_verdict", int'(verdict), 0);
        chk("t5_ev_valid", int'(ev_valid), 0);
        chk("t5_overflow", int'(ev_overflow), 0);

`ifdef SVA_COLLECT_TIMEOUT_EN
        // Scenario 6: four silent periods trip the watchdog
        do_grst();
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (4) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        look();
        chk("t6_verdict", int'(verdict), 3);
        chk("t6_fail_cnt", int'(fail_cnt), 1);
        chk("t6_ev_kind", int'(ev_kind), 0);
        chk("t6_ev_period", int'(ev_period), 3);
        chk("t6_first_fail", int'(first_fail_period), 3);
`endif

        // Async reset mid-operation drops ev_valid without a clock edge
        do_grst();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        look();
        chk("ar_valid_before", int'(ev_valid), 1);
        #1 sys_rst = 1;
        #1;
        chk("ar_valid_after", int'(ev_valid), 0);
        chk("ar_verdict", int'(verdict), 0);
        @(negedge clk);
        sys_rst = 0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(19) == 0) en = !en;
            grst = ($urandom_range(149) == 0);
            tick = ($urandom_range(2) == 0);
            vld  = $urandom_range(1) == 1;
            s    = $urandom_range(1) == 1;
            l    = $urandom_range(1) == 1;
            f    = ($urandom_range(15) == 0);
            rdy  = (i % 400 < 200) ? ($urandom_range(2) != 0) : ($urandom_range(5) == 0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        look();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
